// File: rtl/serial_comparator_2bit.sv
`timescale 1ns/1ps
// serial_comparator_2bit
//   Bit-serial unsigned magnitude comparator. Captures an operand pair on the
//   input handshake. Scans it MSB-first, one bit per clock. Presents exactly one
//   of a_eq_b / a_lt_b / a_gt_b. The result is held until the output handshake.
//
//   Optional build macro: SERIAL_CMP_EARLY_DONE_EN
//     When defined, the scan stops on the edge that finds the first differing bit.
//     When undefined, the scan always takes WIDTH cycles.
//
// Ports
//   clk, rst_n              clock, asynchronous active-low reset
//   in_valid / in_ready     operand handshake (in_ready high only in IDLE)
//   a, b                    WIDTH-bit unsigned operands
//   out_valid / out_ready   result handshake
//   a_eq_b, a_lt_b, a_gt_b  result flags (meaningful while out_valid)
//   busy                    high while comparing or holding a result
module serial_comparator_2bit #(
  parameter int unsigned WIDTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             a_eq_b,
  output logic             a_lt_b,
  output logic             a_gt_b,
  output logic             busy
);

  localparam int unsigned IW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CMP  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_a, r_b, w_a_nxt, w_b_nxt;
  logic [IW-1:0]    r_idx, w_idx_nxt;
  logic             r_decided, r_lt, r_gt;
  logic             w_decided_nxt, w_lt_nxt, w_gt_nxt;
  logic             r_out_valid, r_eq_o, r_lt_o, r_gt_o;
  logic             w_out_valid_nxt, w_eq_o_nxt, w_lt_o_nxt, w_gt_o_nxt;
  logic             w_bit_a, w_bit_b, w_diff, w_last, w_cmp_end;

  // The bit under inspection always sits at the MSB of the shift registers.
  assign w_bit_a = r_a[WIDTH-1];
  assign w_bit_b = r_b[WIDTH-1];
  // Only the first differing bit may set the flags.
  assign w_diff  = !r_decided && (w_bit_a != w_bit_b);
  assign w_last  = (r_idx == '0);

`ifdef SERIAL_CMP_EARLY_DONE_EN
  assign w_cmp_end = w_last || w_diff;
`else
  assign w_cmp_end = w_last;
`endif

  assign in_ready  = (r_state == S_IDLE);
  assign busy      = (r_state != S_IDLE);
  assign out_valid = r_out_valid;
  assign a_eq_b    = r_eq_o;
  assign a_lt_b    = r_lt_o;
  assign a_gt_b    = r_gt_o;

  // State register and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_a         <= '0;
      r_b         <= '0;
      r_idx       <= '0;
      r_decided   <= 1'b0;
      r_lt        <= 1'b0;
      r_gt        <= 1'b0;
      r_out_valid <= 1'b0;
      r_eq_o      <= 1'b0;
      r_lt_o      <= 1'b0;
      r_gt_o      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_a         <= w_a_nxt;
      r_b         <= w_b_nxt;
      r_idx       <= w_idx_nxt;
      r_decided   <= w_decided_nxt;
      r_lt        <= w_lt_nxt;
      r_gt        <= w_gt_nxt;
      r_out_valid <= w_out_valid_nxt;
      r_eq_o      <= w_eq_o_nxt;
      r_lt_o      <= w_lt_o_nxt;
      r_gt_o      <= w_gt_o_nxt;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    w_state_nxt     = r_state;
    w_a_nxt         = r_a;
    w_b_nxt         = r_b;
    w_idx_nxt       = r_idx;
    w_decided_nxt   = r_decided;
    w_lt_nxt        = r_lt;
    w_gt_nxt        = r_gt;
    w_out_valid_nxt = r_out_valid;
    w_eq_o_nxt      = r_eq_o;
    w_lt_o_nxt      = r_lt_o;
    w_gt_o_nxt      = r_gt_o;

    case (r_state)
      S_IDLE: begin
        if (in_valid) begin
          w_a_nxt       = a;
          w_b_nxt       = b;
          w_idx_nxt     = IW'(WIDTH - 1);
          w_decided_nxt = 1'b0;
          w_lt_nxt      = 1'b0;
          w_gt_nxt      = 1'b0;
          w_state_nxt   = S_CMP;
        end
      end
      S_CMP: begin
        w_a_nxt   = r_a << 1;
        w_b_nxt   = r_b << 1;
        w_idx_nxt = r_idx - IW'(1);
        if (w_diff) begin
          w_lt_nxt      = w_bit_b;
          w_gt_nxt      = w_bit_a;
          w_decided_nxt = 1'b1;
        end
        // The flags include the bit resolved on this same edge.
        if (w_cmp_end) begin
          w_state_nxt     = S_DONE;
          w_out_valid_nxt = 1'b1;
          w_eq_o_nxt      = !w_decided_nxt;
          w_lt_o_nxt      = w_lt_nxt;
          w_gt_o_nxt      = w_gt_nxt;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          w_state_nxt     = S_IDLE;
          w_out_valid_nxt = 1'b0;
          w_eq_o_nxt      = 1'b0;
          w_lt_o_nxt      = 1'b0;
          w_gt_o_nxt      = 1'b0;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_serial_comparator_2bit.sv
`timescale 1ns/1ps
module tb_serial_comparator_2bit;

`ifdef SERIAL_CMP_EARLY_DONE_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  always #5 clk = ~clk;

  // WIDTH=2 instance
  logic       in_valid, in_ready, out_valid, out_ready;
  logic [1:0] a, b;
  logic       a_eq_b, a_lt_b, a_gt_b, busy;

  // WIDTH=4 instance
  logic       in_valid4, in_ready4, out_valid4, out_ready4;
  logic [3:0] a4, b4;
  logic       a_eq_b4, a_lt_b4, a_gt_b4, busy4;

  int tests_run = 0;
  int failed    = 0;

  serial_comparator_2bit #(.WIDTH(2)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .a_eq_b(a_eq_b), .a_lt_b(a_lt_b), .a_gt_b(a_gt_b), .busy(busy)
  );

  serial_comparator_2bit #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid4), .in_ready(in_ready4),
    .a(a4), .b(b4), .out_valid(out_valid4), .out_ready(out_ready4),
    .a_eq_b(a_eq_b4), .a_lt_b(a_lt_b4), .a_gt_b(a_gt_b4), .busy(busy4)
  );

  // Reference: accept-to-out_valid latency from the operands.
  function automatic int exp_lat(input int w, input logic [31:0] x, input logic [31:0] y);
    int n;
    n = w;
    for (int p = 0; p < w; p++)
      if (EARLY && (x[p] != y[p])) n = w - p;
    return n;
  endfunction

  // Reference: {eq, lt, gt} from plain arithmetic.
  function automatic logic [2:0] exp_flags(input logic [31:0] x, input logic [31:0] y);
    return {x == y, x < y, x > y};
  endfunction

  // One WIDTH=2 transaction; out_ready held low for 'hold' cycles after out_valid.
  task automatic do_txn(input logic [1:0] ta, input logic [1:0] tb_v, input int hold);
    int cnt;
    logic [2:0] ef;
    ef = exp_flags(32'(ta), 32'(tb_v));
    tests_run++;
    if (in_ready !== 1'b1) begin failed++; $display("FAIL txn_idle_ready: got %b expected 1", in_ready); end
    in_valid = 1'b1; a = ta; b = tb_v;
    @(posedge clk); #1;
    in_valid = 1'b0; a = 2'($urandom); b = 2'($urandom);
    tests_run++;
    if ({busy, in_ready} !== 2'b10) begin
      failed++; $display("FAIL txn_busy: got busy,in_ready=%b expected 10", {busy, in_ready});
    end
    cnt = 0;
    while (out_valid !== 1'b1 && cnt < 20) begin
      out_ready = 1'($urandom);
      @(posedge clk); #1;
      cnt++;
    end
    out_ready = 1'b0;
    tests_run++;
    if (cnt != exp_lat(2, 32'(ta), 32'(tb_v))) begin
      failed++; $display("FAIL txn_latency a=%0d b=%0d: got %0d expected %0d", ta, tb_v, cnt, exp_lat(2, 32'(ta), 32'(tb_v)));
    end
    tests_run++;
    if ({a_eq_b, a_lt_b, a_gt_b} !== ef) begin
      failed++; $display("FAIL txn_flags a=%0d b=%0d: got %b expected %b", ta, tb_v, {a_eq_b, a_lt_b, a_gt_b}, ef);
    end
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      tests_run++;
      if ({out_valid, in_ready, a_eq_b, a_lt_b, a_gt_b} !== {2'b10, ef}) begin
        failed++; $display("FAIL txn_hold cycle %0d: got %b expected %b", i, {out_valid, in_ready, a_eq_b, a_lt_b, a_gt_b}, {2'b10, ef});
      end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    tests_run++;
    if ({out_valid, a_eq_b, a_lt_b, a_gt_b, busy, in_ready} !== 6'b000001) begin
      failed++; $display("FAIL txn_release: got %b expected 000001", {out_valid, a_eq_b, a_lt_b, a_gt_b, busy, in_ready});
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
    in_valid4 = 1'b0; out_ready4 = 1'b0; a4 = '0; b4 = '0;
    #12;
    tests_run++;
    if ({out_valid, a_eq_b, a_lt_b, a_gt_b, busy, in_ready} !== 6'b000001) begin
      failed++; $display("FAIL reset_values: got %b expected 000001", {out_valid, a_eq_b, a_lt_b, a_gt_b, busy, in_ready});
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_directed();
    do_txn(2'b00, 2'b00, 0);
    do_txn(2'b01, 2'b00, 0);
    do_txn(2'b10, 2'b11, 0);
    do_txn(2'b11, 2'b10, 0);
    do_txn(2'b11, 2'b11, 0);
  endtask

  task automatic test_hold();
    do_txn(2'b01, 2'b10, 5);
  endtask

  task automatic test_ignore_busy();
    int cnt;
    logic seen;
    in_valid = 1'b1; a = 2'b00; b = 2'b01;
    @(posedge clk); #1;
    in_valid = 1'b1; a = 2'b11; b = 2'b00;   // pulse while comparing
    @(posedge clk); #1;
    in_valid = 1'b0;
    cnt = 1;
    while (out_valid !== 1'b1 && cnt < 20) begin @(posedge clk); #1; cnt++; end
    tests_run++;
    if ({out_valid, a_eq_b, a_lt_b, a_gt_b} !== 4'b1010) begin
      failed++; $display("FAIL ignore_flags: got %b expected 1010", {out_valid, a_eq_b, a_lt_b, a_gt_b});
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b0 || busy !== 1'b0) seen = 1'b1;
    end
    tests_run++;
    if (seen !== 1'b0) begin failed++; $display("FAIL ignore_no_capture: got activity=%b expected 0", seen); end
  endtask

  task automatic test_back_to_back();
    logic [1:0] v;
    v = 2'($urandom);
    in_valid = 1'b1; out_ready = 1'b1; a = v; b = v;
    // Accepts on edges 1, 5, 9: out_valid after edges 3, 7, 11; IDLE after 4, 8, 12.
    for (int j = 1; j <= 12; j++) begin
      @(posedge clk); #1;
      tests_run++;
      if ({out_valid, in_ready} !== {(j >= 3) && ((j - 3) % 4 == 0), (j % 4 == 0)}) begin
        failed++; $display("FAIL back_to_back edge %0d: got ov,ir=%b expected %b", j, {out_valid, in_ready},
                           {(j >= 3) && ((j - 3) % 4 == 0), (j % 4 == 0)});
      end
    end
    in_valid = 1'b0; out_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic seen;
    int cnt;
    // Reset during CMP.
    in_valid = 1'b1; a = 2'b11; b = 2'b01;
    @(posedge clk); #1;
    in_valid = 1'b0;
    #2; rst_n = 1'b0; #1;
    tests_run++;
    if ({out_valid, a_eq_b, a_lt_b, a_gt_b, busy, in_ready} !== 6'b000001) begin
      failed++; $display("FAIL reset_mid_cmp: got %b expected 000001", {out_valid, a_eq_b, a_lt_b, a_gt_b, busy, in_ready});
    end
    #2; rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin @(posedge clk); #1; if (out_valid !== 1'b0 || busy !== 1'b0) seen = 1'b1; end
    tests_run++;
    if (seen !== 1'b0) begin failed++; $display("FAIL reset_mid_cmp_stale: got activity=%b expected 0", seen); end
    // Reset while holding a result.
    in_valid = 1'b1; a = 2'b10; b = 2'b01;
    @(posedge clk); #1;
    in_valid = 1'b0;
    cnt = 0;
    while (out_valid !== 1'b1 && cnt < 20) begin @(posedge clk); #1; cnt++; end
    #2; rst_n = 1'b0; #1;
    tests_run++;
    if ({out_valid, a_eq_b, a_lt_b, a_gt_b, busy, in_ready} !== 6'b000001) begin
      failed++; $display("FAIL reset_mid_done: got %b expected 000001", {out_valid, a_eq_b, a_lt_b, a_gt_b, busy, in_ready});
    end
    #2; rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin @(posedge clk); #1; if (out_valid !== 1'b0) seen = 1'b1; end
    tests_run++;
    if (seen !== 1'b0) begin failed++; $display("FAIL reset_mid_done_stale: got activity=%b expected 0", seen); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) do_txn(2'($urandom), 2'($urandom), int'($urandom_range(0, 3)));
  endtask

  task automatic test_width4();
    logic [3:0] ta, tb_v;
    logic [2:0] ef;
    int cnt;
    for (int i = 0; i < 12; i++) begin
      if (i == 0) begin ta = 4'b1000; tb_v = 4'b0111; end
      else begin ta = 4'($urandom); tb_v = (i % 4 == 0) ? ta : 4'($urandom); end
      ef = exp_flags(32'(ta), 32'(tb_v));
      in_valid4 = 1'b1; a4 = ta; b4 = tb_v;
      @(posedge clk); #1;
      in_valid4 = 1'b0; a4 = 4'($urandom); b4 = 4'($urandom);
      cnt = 0;
      while (out_valid4 !== 1'b1 && cnt < 20) begin @(posedge clk); #1; cnt++; end
      tests_run++;
      if (cnt != exp_lat(4, 32'(ta), 32'(tb_v))) begin
        failed++; $display("FAIL w4_latency a=%0d b=%0d: got %0d expected %0d", ta, tb_v, cnt, exp_lat(4, 32'(ta), 32'(tb_v)));
      end
      tests_run++;
      if ({a_eq_b4, a_lt_b4, a_gt_b4} !== ef) begin
        failed++; $display("FAIL w4_flags a=%0d b=%0d: got %b expected %b", ta, tb_v, {a_eq_b4, a_lt_b4, a_gt_b4}, ef);
      end
      out_ready4 = 1'b1;
      @(posedge clk); #1;
      out_ready4 = 1'b0;
      tests_run++;
      if ({out_valid4, busy4, in_ready4} !== 3'b001) begin
        failed++; $display("FAIL w4_release: got %b expected 001", {out_valid4, busy4, in_ready4});
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_hold();
    test_ignore_busy();
    test_back_to_back();
    test_reset_mid();
    test_random();
    test_width4();
    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

endmodule
